// File: rtl/botoes_contador.sv
// botoes_contador: synchronizes and debounces two raw push buttons and sequences
// them into single-cycle acrescer/decrescer pulses with optional auto-repeat.

module botoes_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Level flips on the edge where the mismatch count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module botoes_contador #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000,
  parameter int REPEAT_EN       = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_acrescer,
  input  logic btn_decrescer,
  output logic acrescer,
  output logic decrescer,
  output logic ocupado
);
  localparam int            NUM_BTN   = 2;
  localparam int            TMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            TW        = $clog2(TMAX);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic          REP       = (REPEAT_EN != 0);

  localparam logic [1:0] OCIOSO      = 2'd0;
  localparam logic [1:0] ESPERA_HOLD = 2'd1;
  localparam logic [1:0] REPETINDO   = 2'd2;
  localparam logic [1:0] BLOQUEADO   = 2'd3;

  // Lane 1 = up (acrescer), lane 0 = down (decrescer).
  logic [NUM_BTN-1:0] raw, db;
  assign raw = {btn_acrescer, btn_decrescer};

  botoes_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (raw),
    .level (db)
  );

  logic [1:0]    state, state_n;
  logic          dir, dir_n;
  logic [TW-1:0] timer, timer_n;
  logic          up_n, dn_n;
  logic          dir_btn, oth_btn, expiry;

  assign dir_btn = dir ? db[1] : db[0];
  assign oth_btn = dir ? db[0] : db[1];
  assign expiry  = (state == ESPERA_HOLD) ? (REP && (timer == HOLD_LAST))
                                          : (timer == REP_LAST);

  // Release beats conflict, conflict beats timer expiry.
  always_comb begin
    state_n = state;
    dir_n   = dir;
    timer_n = timer;
    up_n    = 1'b0;
    dn_n    = 1'b0;
    case (state)
      OCIOSO: begin
        if (db[1] && db[0]) begin
          state_n = BLOQUEADO;
        end else if (db[1] || db[0]) begin
          dir_n   = db[1];
          up_n    = db[1];
          dn_n    = db[0];
          timer_n = '0;
          state_n = ESPERA_HOLD;
        end
      end
      ESPERA_HOLD, REPETINDO: begin
        if (!dir_btn) begin
          state_n = OCIOSO;
        end else if (oth_btn) begin
          state_n = BLOQUEADO;
        end else if (expiry) begin
          up_n    = dir;
          dn_n    = ~dir;
          timer_n = '0;
          state_n = REPETINDO;
        end else if (state == REPETINDO || REP || timer != HOLD_LAST) begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        if (!db[1] && !db[0]) state_n = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCIOSO;
      dir       <= 1'b0;
      timer     <= '0;
      acrescer  <= 1'b0;
      decrescer <= 1'b0;
      ocupado   <= 1'b0;
    end else begin
      state     <= state_n;
      dir       <= dir_n;
      timer     <= timer_n;
      acrescer  <= up_n;
      decrescer <= dn_n;
      ocupado   <= (state_n != OCIOSO);
    end
  end
endmodule

// File: tb/tb_botoes_contador.sv
// Bench for botoes_contador: two instances (auto-repeat on / off) share stimulus;
// expected pulses are queued as cycle*2+up and popped as the DUTs emit them.
module tb_botoes_contador;
  localparam int D = 4;
  localparam int H = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_up, btn_dn;
  logic a0, d0, o0, a1, d1, o1;

  always #5 clk = ~clk;

  botoes_contador #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(1)) u_dut_rep (
    .clk(clk), .rst_n(rst_n), .btn_acrescer(btn_up), .btn_decrescer(btn_dn),
    .acrescer(a0), .decrescer(d0), .ocupado(o0));

  botoes_contador #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .REPEAT_EN(0)) u_dut_one (
    .clk(clk), .rst_n(rst_n), .btn_acrescer(btn_up), .btn_decrescer(btn_dn),
    .acrescer(a1), .decrescer(d1), .ocupado(o1));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int cnt0  = 0;
  int q0[$];
  int q1[$];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_pulse(int t, bit up, bit both);
    q0.push_back(t * 2 + int'(up));
    if (both) q1.push_back(t * 2 + int'(up));
  endtask

  // One cycle: advance to the falling edge, then score any emitted pulse.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (a0 || d0) begin
      chk("excl0", int'(a0 & d0), 0);
      if (q0.size() == 0) chk("spurious0", cyc * 2 + int'(a0), -1);
      else                chk("pulse0", cyc * 2 + int'(a0), q0.pop_front());
      cnt0 += a0 ? 1 : -1;
    end
    if (a1 || d1) begin
      chk("excl1", int'(a1 & d1), 0);
      if (q1.size() == 0) chk("spurious1", cyc * 2 + int'(a1), -1);
      else                chk("pulse1", cyc * 2 + int'(a1), q1.pop_front());
    end
  endtask

  task automatic wait_until(int t);
    while (cyc < t) step();
  endtask

  task automatic drain(string tag);
    chk({tag, "_missing0"}, q0.size(), 0);
    chk({tag, "_missing1"}, q1.size(), 0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, k2, kd, r, base;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    repeat (3) step();
    chk("rst_acr", a0, 0);
    chk("rst_dec", d0, 0);
    chk("rst_ocup", o0, 0);
    chk("rst_ocup1", o1, 0);
    rst_n = 1'b1;
    repeat (5) step();

    // Clean press: held for 10 samples, one pulse k+2+D after first sample.
    btn_up = 1'b1; k = cyc + 1;
    exp_pulse(k + 2 + D, 1'b1, 1'b1);
    wait_until(k + 5);  chk("clean_ocup_pre", o0, 0);
    wait_until(k + 6);  chk("clean_ocup_on", o0, 1); chk("clean_ocup_on1", o1, 1);
    wait_until(k + 9);  btn_up = 1'b0; r = cyc + 1;
    wait_until(r + 5);  chk("clean_ocup_hold", o0, 1);
    wait_until(r + 6);  chk("clean_ocup_off", o0, 0); chk("clean_ocup_off1", o1, 0);
    wait_until(r + 10); drain("clean");

    // Bounce on down: only the final rising sample starts a surviving count.
    btn_dn = 1'b1; step();
    btn_dn = 1'b0; step();
    btn_dn = 1'b1; step();
    btn_dn = 1'b0; step();
    btn_dn = 1'b1; k = cyc + 1;
    exp_pulse(k + 6, 1'b0, 1'b1);
    wait_until(k + 11); btn_dn = 1'b0; r = cyc + 1;
    wait_until(r + 8);  drain("bounce");

    // Auto-repeat: 40-sample hold covers P, P+H, P+H+R, P+H+2R before release lands.
    base = cnt0;
    btn_up = 1'b1; k = cyc + 1;
    exp_pulse(k + 6, 1'b1, 1'b1);
    exp_pulse(k + 6 + H, 1'b1, 1'b0);
    exp_pulse(k + 6 + H + R, 1'b1, 1'b0);
    exp_pulse(k + 6 + H + 2 * R, 1'b1, 1'b0);
    wait_until(k + 39); btn_up = 1'b0; r = cyc + 1;
    wait_until(r + 8);  drain("repeat");
    chk("repeat_count", cnt0 - base, 4);

    // Conflict: down joins 5 cycles into an up hold; block until both released.
    btn_up = 1'b1; k = cyc + 1;
    exp_pulse(k + 6, 1'b1, 1'b1);
    wait_until(k + 4);  btn_dn = 1'b1; kd = cyc + 1;
    wait_until(kd + 25); chk("conf_blk", o0, 1); chk("conf_blk1", o1, 1);
    btn_up = 1'b0;
    wait_until(cyc + 20); chk("conf_up_rel", o0, 1);
    btn_dn = 1'b0; r = cyc + 1;
    wait_until(r + 5);  chk("conf_rel_hold", o0, 1);
    wait_until(r + 6);  chk("conf_rel_idle", o0, 0);
    wait_until(r + 8);
    btn_dn = 1'b1; k2 = cyc + 1;
    exp_pulse(k2 + 6, 1'b0, 1'b1);
    wait_until(k2 + 9); btn_dn = 1'b0;
    wait_until(cyc + 10); drain("conflict");

    // Simultaneous press: no pulses, busy while either is held.
    btn_up = 1'b1; btn_dn = 1'b1; k = cyc + 1;
    wait_until(k + 5);  chk("simul_pre", o0, 0);
    wait_until(k + 6);  chk("simul_blk", o0, 1); chk("simul_blk1", o1, 1);
    wait_until(k + 19); btn_up = 1'b0; btn_dn = 1'b0; r = cyc + 1;
    wait_until(r + 5);  chk("simul_hold", o0, 1);
    wait_until(r + 6);  chk("simul_idle", o0, 0);
    wait_until(r + 8);  drain("simul");

    // Reset mid-REPETINDO with the button still held: outputs clear at once,
    // then a fresh press is seen from the first edge after reset release.
    btn_up = 1'b1; k = cyc + 1;
    exp_pulse(k + 6, 1'b1, 1'b1);
    exp_pulse(k + 6 + H, 1'b1, 1'b0);
    wait_until(k + 30);
    rst_n = 1'b0;
    #1;
    chk("arst_acr", a0, 0);
    chk("arst_dec", d0, 0);
    chk("arst_ocup", o0, 0);
    chk("arst_ocup1", o1, 0);
    step();
    base = cnt0;
    rst_n = 1'b1; k2 = cyc + 1;
    exp_pulse(k2 + 6, 1'b1, 1'b1);
    wait_until(k2 + 12); btn_up = 1'b0;
    wait_until(cyc + 10); drain("arst");
    chk("arst_count", cnt0 - base, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
